hazard_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage RISC-V core. Each cycle it decides the write-enable and flush of every pipeline register. It freezes the whole pipe while the instruction or data memory wrapper is busy, flushes wrong-path instructions on a taken branch or jump, and inserts a configurable number of load-use bubbles. It sits beside the forwarding unit and drives the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It also keeps two performance counters.

---
 rtl/hazard_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller with load-use bubbles, memory freeze and perf counters
module hazard_ctrl #(
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1_addr,
  input  logic [4:0]       ID_rs2_addr,
  input  logic             ID_rs1_used,
  input  logic             ID_rs2_used,
  input  logic             EXE_MemRead,
  input  logic [4:0]       EXE_rd_addr,
  input  logic             EXE_branch_taken,
  input  logic             IM_stall,
  input  logic             DM_stall,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IDEXE_en,
  output logic             EXEMEM_en,
  output logic             MEMWB_en,
  output logic             IFID_flush,
  output logic             IDEXE_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;
  localparam logic [1:0] LU_INIT = 2'(LOAD_USE_STALL - 1);
  state_t           r_state, w_state_nxt;
  logic [1:0]       r_lu_cnt, w_lu_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cycles, r_flush_count;
  logic             w_mem_busy, w_lu_hit;
  assign w_mem_busy   = IM_stall | DM_stall;
  assign w_lu_hit     = EXE_MemRead & (EXE_rd_addr != 5'd0) &
                        ((ID_rs1_used & (ID_rs1_addr == EXE_rd_addr)) |
                         (ID_rs2_used & (ID_rs2_addr == EXE_rd_addr)));
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
  // FSM state and remaining-bubble counter; async reset drops any pending bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RUN;
      r_lu_cnt <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_lu_cnt <= w_lu_cnt_nxt;
    end
  end
  // performance counters: frozen cycles and taken-branch flushes, wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_mem_busy) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (!w_mem_busy && EXE_branch_taken) r_flush_count <= r_flush_count + 1'b1;
    end
  end
  // next state and enables: freeze > branch flush > load-use bubble > run
  always_comb begin
    w_state_nxt  = r_state;
    w_lu_cnt_nxt = r_lu_cnt;
    PC_en        = 1'b0;
    IFID_en      = 1'b0;
    IDEXE_en     = 1'b0;
    EXEMEM_en    = 1'b0;
    MEMWB_en     = 1'b0;
    IFID_flush   = 1'b0;
    IDEXE_flush  = 1'b0;
    if (rst && !w_mem_busy) begin
      IDEXE_en  = 1'b1;
      EXEMEM_en = 1'b1;
      MEMWB_en  = 1'b1;
      if (EXE_branch_taken) begin
        PC_en        = 1'b1;
        IFID_en      = 1'b1;
        IFID_flush   = 1'b1;
        IDEXE_flush  = 1'b1;
        w_state_nxt  = RUN;
        w_lu_cnt_nxt = 2'd0;
      end else if (r_state == LU_STALL) begin
        IDEXE_flush  = 1'b1;
        w_lu_cnt_nxt = r_lu_cnt - 2'd1;
        w_state_nxt  = (r_lu_cnt == 2'd1) ? RUN : LU_STALL;
      end else if (w_lu_hit) begin
        IDEXE_flush = 1'b1;
        if (LOAD_USE_STALL > 1) begin
          w_state_nxt  = LU_STALL;
          w_lu_cnt_nxt = LU_INIT;
        end
      end else begin
        PC_en   = 1'b1;
        IFID_en = 1'b1;
      end
    end
  end
endmodule
